// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with scan-based press/release debounce.
// Single-key only: a scan showing two or more keys never yields a new key.
module keypad_scanner #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int         DW = $clog2(SCAN_DIV);
    localparam logic [3:0] DB = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    col_q, col_d;
    logic [15:0]   hits_q, hits_d;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;

    logic          last, scan_done;
    logic [15:0]   cur_hits, scan_hits;
    logic [4:0]    nhit;
    logic [3:0]    code, cnt_inc;
    scan_t         cls;

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

    // Column scan timing and per-scan hit accumulation, indexed {row, col}.
    always_comb begin
        last      = dwell_q == DW'(SCAN_DIV - 1);
        scan_done = last && col_idx_q == 2'd3;
        dwell_d   = last ? '0 : dwell_q + DW'(1);
        col_idx_d = last ? col_idx_q + 2'd1 : col_idx_q;
        col_d     = last ? ~(4'b0001 << col_idx_d) : col_q;
        cur_hits  = '0;
        for (int r = 0; r < 4; r++)
            cur_hits[r*4 + int'(col_idx_q)] = ~row_s2_q[r];
        scan_hits = hits_q | cur_hits;
        hits_d    = last ? (scan_done ? '0 : scan_hits) : hits_q;
        nhit      = '0;
        code      = '0;
        for (int i = 0; i < 16; i++)
            if (scan_hits[i]) begin
                nhit = nhit + 5'd1;
                code = 4'(i);
            end
        cls     = nhit == 5'd0 ? NONE : nhit == 5'd1 ? SINGLE : MULTI;
        cnt_inc = cnt_q == 4'hF ? cnt_q : cnt_q + 4'd1;
    end

    // Debounce state machine, advanced only on completed scans.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (scan_done) begin
            case (state_q)
                IDLE:
                    if (cls == SINGLE) begin
                        cand_d  = code;
                        cnt_d   = 4'd1;
                        state_d = DEBOUNCE;
                        if (DB == 4'd1) begin
                            state_d     = PRESSED;
                            key_code_d  = code;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end
                DEBOUNCE:
                    if (cls != SINGLE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (code != cand_q) begin
                        cand_d = code;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB) begin
                            state_d     = PRESSED;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end
                PRESSED:
                    if (cls == NONE) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                        if (DB == 4'd1) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end
                    end
                default:
                    if (cls == NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q    <= 4'hF;
            row_s2_q    <= 4'hF;
            col_idx_q   <= '0;
            dwell_q     <= '0;
            col_q       <= 4'b1110;
            hits_q      <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            row_s1_q    <= row;
            row_s2_q    <= row_s1_q;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, release, multi-key and reset abort.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  col, row, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = '0;
    int          vecs = 0, errs = 0, pulses = 0;
    logic        kv_prev = 1'b0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk(clk), .rst(rst), .col(col), .row(row),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a row reads low when a pressed key joins it to the driven column.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            row[r] = ~|(keys[r*4 +: 4] & ~col);
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses++;
            vecs++;
            if (kv_prev) begin
                errs++;
                $display("FAIL kv_consecutive key_valid high two cycles");
            end
        end
        kv_prev <= key_valid;
    end

    task automatic next_scan();
        logic [3:0] prev;
        int n;
        bit done;
        prev = col;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (prev == 4'b0111 && col == 4'b1110) done = 1;
            else if (n > 100) begin
                vecs++; errs++;
                $display("FAIL scan_timeout col=%b", col);
                done = 1;
            end
            prev = col;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        keys = '0;
        repeat (3) @(negedge clk);
        vecs++; if (col !== 4'b1110) begin errs++; $display("FAIL rst_col got=%b exp=1110", col); end
        vecs++; if (key_code !== 4'h0) begin errs++; $display("FAIL rst_code got=%h exp=0", key_code); end
        vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL rst_held got=%b exp=0", key_held); end
    endtask

    task automatic test_idle();
        logic [3:0] exp_col;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            vecs++;
            if (col !== exp_col) begin errs++; $display("FAIL idle_col i=%0d got=%b exp=%b", i, col, exp_col); end
            @(negedge clk);
        end
        next_scan();
        next_scan();
        vecs++; if (pulses != 0) begin errs++; $display("FAIL idle_pulses got=%0d exp=0", pulses); end
        vecs++; if (key_code !== 4'h0) begin errs++; $display("FAIL idle_code got=%h exp=0", key_code); end
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        keys[9] = 1'b1;
        next_scan();
        vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL sp_scan1_valid got=%b exp=0", key_valid); end
        next_scan();
        vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL sp_scan2_valid got=%b exp=1", key_valid); end
        vecs++; if (key_code !== 4'b1001) begin errs++; $display("FAIL sp_code got=%b exp=1001", key_code); end
        vecs++; if (key_held !== 1'b1) begin errs++; $display("FAIL sp_held got=%b exp=1", key_held); end
        next_scan();
        vecs++; if (pulses != p0 + 1) begin errs++; $display("FAIL sp_pulses got=%0d exp=%0d", pulses, p0 + 1); end
    endtask

    task automatic test_release();
        int p0;
        keys = '0;
        next_scan();
        vecs++; if (key_held !== 1'b1) begin errs++; $display("FAIL rel_scan1_held got=%b exp=1", key_held); end
        next_scan();
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL rel_scan2_held got=%b exp=0", key_held); end
        vecs++; if (key_code !== 4'b1001) begin errs++; $display("FAIL rel_code got=%b exp=1001", key_code); end
        next_scan();
        next_scan();
        p0 = pulses;
        keys[9] = 1'b1;
        next_scan();
        next_scan();
        vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL repress_valid got=%b exp=1", key_valid); end
        vecs++; if (pulses != p0 + 1) begin errs++; $display("FAIL repress_pulses got=%0d exp=%0d", pulses, p0 + 1); end
        keys = '0;
        next_scan();
        next_scan();
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulses;
        keys[0] = 1'b1;
        keys[15] = 1'b1;
        next_scan();
        next_scan();
        vecs++; if (pulses != p0) begin errs++; $display("FAIL multi_pulses got=%0d exp=%0d", pulses, p0); end
        vecs++; if (key_code !== 4'b1001) begin errs++; $display("FAIL multi_code_hold got=%b exp=1001", key_code); end
        keys[15] = 1'b0;
        next_scan();
        vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL multi_scan1_valid got=%b exp=0", key_valid); end
        next_scan();
        vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL multi_valid got=%b exp=1", key_valid); end
        vecs++; if (key_code !== 4'b0000) begin errs++; $display("FAIL multi_code got=%b exp=0000", key_code); end
        keys = '0;
        next_scan();
        next_scan();
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL multi_rel_held got=%b exp=0", key_held); end
    endtask

    task automatic test_bounce();
        int p0;
        p0 = pulses;
        keys[6] = 1'b1;
        next_scan();
        keys[6] = 1'b0;
        next_scan();
        keys[6] = 1'b1;
        next_scan();
        vecs++; if (pulses != p0) begin errs++; $display("FAIL bounce_early got=%0d exp=%0d", pulses, p0); end
        next_scan();
        vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL bounce_valid got=%b exp=1", key_valid); end
        vecs++; if (key_code !== 4'b0110) begin errs++; $display("FAIL bounce_code got=%b exp=0110", key_code); end
        vecs++; if (pulses != p0 + 1) begin errs++; $display("FAIL bounce_pulses got=%0d exp=%0d", pulses, p0 + 1); end
        keys = '0;
        next_scan();
        next_scan();
    endtask

    task automatic test_reset_mid_debounce();
        int p0;
        logic [3:0] exp_col;
        p0 = pulses;
        keys[9] = 1'b1;
        next_scan();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vecs++; if (col !== 4'b1110) begin errs++; $display("FAIL rmid_col got=%b exp=1110", col); end
        vecs++; if (key_code !== 4'h0) begin errs++; $display("FAIL rmid_code got=%h exp=0", key_code); end
        vecs++; if (key_held !== 1'b0) begin errs++; $display("FAIL rmid_held got=%b exp=0", key_held); end
        repeat (20) @(negedge clk);
        vecs++; if (pulses != p0) begin errs++; $display("FAIL rmid_pulses got=%0d exp=%0d", pulses, p0); end
        keys = '0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            vecs++;
            if (col !== exp_col) begin errs++; $display("FAIL rmid_dwell i=%0d got=%b exp=%b", i, col, exp_col); end
            @(negedge clk);
        end
        next_scan();
        keys[9] = 1'b1;
        next_scan();
        next_scan();
        vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL rmid_resume_valid got=%b exp=1", key_valid); end
        vecs++; if (key_code !== 4'b1001) begin errs++; $display("FAIL rmid_resume_code got=%b exp=1001", key_code); end
        vecs++; if (pulses != p0 + 1) begin errs++; $display("FAIL rmid_resume_pulses got=%0d exp=%0d", pulses, p0 + 1); end
        keys = '0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_press();
        test_release();
        test_multi();
        test_bounce();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles each column is driven (1 ms at 100 MHz); legal values >= 4.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive full scans required to accept a press or a release; legal values 1..15.
REQ-003 SHALL have port clk, input, 1 bit: 100 MHz master clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port col, output, 4 bits: keypad column drive, active-low one-hot.
REQ-006 SHALL have port row, input, 4 bits: keypad row sense, active-low, asynchronous to clk (external pull-ups).
REQ-007 SHALL have port key_code, output, 4 bits: last accepted key, encoded {row_idx[1:0], col_idx[1:0]}.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse on each accepted press.
REQ-009 SHALL have port key_held, output, 1 bit: level, high while an accepted key is considered down.

Function
REQ-010 SHALL pass row through a two-flop synchronizer; only the synchronized value is used.
REQ-011 SHALL drive exactly one col bit low at all times: col_idx 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111.
REQ-012 SHALL hold each column for exactly SCAN_DIV cycles, then advance col_idx by 1, wrapping 3 -> 0; the full scan period is 4*SCAN_DIV cycles.
REQ-013 SHALL sample synchronized row in the last cycle of each column dwell (dwell counter == SCAN_DIV-1).
REQ-014 SHALL accumulate samples over columns 0..3; at the column-3 sample, classify the scan: NONE (no row low in any column), SINGLE (exactly one row/column intersection low, with its code), or MULTI (two or more).
REQ-015 SHALL run state machine IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated only at scan completion; the debounce counter counts scans.
REQ-016 IDLE: SINGLE -> DEBOUNCE, candidate = code, count = 1; NONE or MULTI -> stay IDLE.
REQ-017 DEBOUNCE: SINGLE with the same code increments count; SINGLE with a different code restarts with the new candidate, count = 1; NONE or MULTI -> IDLE.
REQ-018 DEBOUNCE: when count reaches DEBOUNCE_SCANS (immediately on entry if DEBOUNCE_SCANS = 1) -> PRESSED; key_code <= candidate, key_held <= 1, and key_valid high for exactly the next cycle.
REQ-019 PRESSED: SINGLE (any code) or MULTI -> stay, with no new key_valid (no auto-repeat, no rollover); NONE -> RELEASE, count = 1.
REQ-020 RELEASE: NONE increments count, and on reaching DEBOUNCE_SCANS -> IDLE with key_held <= 0; SINGLE or MULTI -> PRESSED, no key_valid.
REQ-021 SHALL hold key_code at the last accepted value through release and IDLE; it changes only together with a key_valid pulse.
REQ-022 SHALL never assert key_valid on two consecutive cycles; the minimum spacing between pulses is 2*DEBOUNCE_SCANS scans.
REQ-023 The debounce counter SHALL saturate and never wrap.

Reset
REQ-024 While rst is low: col = 4'b1110, col_idx = 0, dwell counter = 0, synchronizer flops = 4'b1111, state = IDLE, count = 0, key_code = 4'h0, key_valid = 0, key_held = 0.
REQ-025 Reset asserted mid-press or mid-debounce SHALL abort immediately without emitting key_valid; after release, scanning restarts at column 0 with a full dwell.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2)
REQ-026 Idle: row = 4'hF after reset -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; key_code = 0.
REQ-027 Single press: pull row[2] low while col = 1101, held for 3 scans -> exactly one key_valid pulse at the end of scan 2, key_code = 4'b1001, key_held = 1.
REQ-028 Bounce: key present for 1 scan, absent for 1 scan, present for 2 scans -> one key_valid only, at the end of the 4th scan.
REQ-029 Release: after REQ-027, release the key -> key_held falls at the end of the 2nd empty scan; key_code stays 4'b1001; a re-press 2 scans later yields a second pulse.
REQ-030 Multi-key: keys (row0,col0) and (row3,col3) pressed together from IDLE -> no key_valid; release (row3,col3) -> key_valid after 2 scans with key_code = 4'b0000.
REQ-031 Reset mid-debounce: assert rst during the 2nd scan of a press -> no key_valid; all outputs at reset values; after release, normal press detection resumes.
